// File: rtl/apb_pkg.sv
// Shared APB definitions: GPIO register offsets, completer FSM encoding and
// error-cause codes also used by the APB master verification environment.
package apb_pkg;

  // Word offsets, decoded from PADDR[4:2]
  localparam logic [2:0] OFF_DOUT  = 3'd0;
  localparam logic [2:0] OFF_DIR   = 3'd1;
  localparam logic [2:0] OFF_DIN   = 3'd2;
  localparam logic [2:0] OFF_IEN   = 3'd3;
  localparam logic [2:0] OFF_ISTAT = 3'd4;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_UNMAPPED   = 3'd1;
  localparam logic [2:0] ERR_MISALIGNED = 3'd2;
  localparam logic [2:0] ERR_READ_ONLY  = 3'd3;
  localparam logic [2:0] ERR_PROT       = 3'd4;

  typedef struct packed {
    logic [1:0] state;
    logic [3:0] wait_cnt;
  } fsm_dbg_t;

  // Misalignment takes priority over the other causes
  function automatic logic [2:0] err_cause(input logic [4:0] addr,
                                           input logic       write,
                                           input logic       prot0);
    logic [2:0] cause;
    cause = ERR_NONE;
    if (addr[1:0] != 2'b00)                       cause = ERR_MISALIGNED;
    else if (addr[4:2] > OFF_ISTAT)               cause = ERR_UNMAPPED;
    else if (write && addr[4:2] == OFF_DIN)       cause = ERR_READ_ONLY;
    else if (write && addr[4:2] == OFF_DIR && !prot0) cause = ERR_PROT;
    return cause;
  endfunction

endpackage

// File: rtl/apb_gpio_slave_if.sv
// APB completer-side bus bundle for the GPIO bank.
// Handshake: a transfer starts with PSEL=1/PENABLE=0 (setup), holds all request
// fields through the access phase with PENABLE=1, and completes in the single
// cycle where PREADY=1; PRDATA/PSLVERR are meaningful only in that cycle.
interface apb_gpio_slave_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8
);
  logic                     PSEL;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [ADDRESS_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0]    PWDATA;
  logic [STRB_WIDTH-1:0]    PSTRB;
  logic [2:0]               PPROT;
  logic [DATA_WIDTH-1:0]    PRDATA;
  logic                     PREADY;
  logic                     PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_slave_gpio_in_sync.sv
// Two-flop synchronizer for the asynchronous GPIO pins, plus a previous-value
// register that yields a one-cycle rising-edge pulse per pin.
module gpio_in_sync #(
  parameter int GPIO_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] din,
  output logic [GPIO_WIDTH-1:0] rise
);
  logic [GPIO_WIDTH-1:0] meta;
  logic [GPIO_WIDTH-1:0] prev;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      meta <= '0;
      din  <= '0;
      prev <= '0;
    end else begin
      meta <= gpio_in;
      din  <= meta;
      prev <= din;
    end
  end

  assign rise = din & ~prev;
endmodule

// File: rtl/apb_gpio_slave.sv
// APB completer for one GPIO bank: register file, wait-state FSM, error decode
// and level interrupt. PREADY depends only on registered FSM state.
module apb_gpio_slave
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int GPIO_WIDTH    = 32,
  parameter int WAIT_STATES   = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_gpio_slave_if.slave       apb,
  input  logic [GPIO_WIDTH-1:0] GPIO_IN,
  output logic [GPIO_WIDTH-1:0] GPIO_OUT,
  output logic [GPIO_WIDTH-1:0] GPIO_OE,
  output logic                  IRQ,
  output fsm_dbg_t              dbg
);
  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic [GPIO_WIDTH-1:0] dout, dir, ien, istat, din, rise;
  logic [DATA_WIDTH-1:0] bmask, rd_data;
  logic [GPIO_WIDTH-1:0] wmask, wdata, clr;
  logic [2:0]            cause, off;
  logic                  access_done, complete, err, wr_en;

  gpio_in_sync #(.GPIO_WIDTH(GPIO_WIDTH)) u_sync (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .gpio_in(GPIO_IN),
    .din    (din),
    .rise   (rise)
  );

  assign access_done = (state == ST_ACCESS) && (wait_cnt == 4'd0);
  // A completion cycle with PSEL already dropped is an abort: no side effects
  assign complete    = access_done && apb.PSEL;
  assign off         = apb.PADDR[4:2];
  assign cause       = err_cause(apb.PADDR[4:0], apb.PWRITE, apb.PPROT[0]);
  assign err         = (cause != ERR_NONE);
  assign wr_en       = complete && apb.PWRITE && !err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (apb.PSEL && !apb.PENABLE) begin
            state    <= ST_ACCESS;
            wait_cnt <= 4'(WAIT_STATES);
          end
        end
        ST_ACCESS: begin
          if (!apb.PSEL || wait_cnt == 4'd0) state <= ST_IDLE;
          else                               wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bmask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) bmask[i] = apb.PSTRB[i/8];
  end

  assign wmask = bmask[GPIO_WIDTH-1:0];
  assign wdata = apb.PWDATA[GPIO_WIDTH-1:0] & wmask;
  assign clr   = (wr_en && off == OFF_ISTAT) ? wdata : '0;

  // New rising edges are OR-ed in after the W1C clear, so a same-cycle set wins
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      dout  <= '0;
      dir   <= '0;
      ien   <= '0;
      istat <= '0;
      IRQ   <= 1'b0;
    end else begin
      if (wr_en && off == OFF_DOUT) dout <= (dout & ~wmask) | wdata;
      if (wr_en && off == OFF_DIR)  dir  <= (dir  & ~wmask) | wdata;
      if (wr_en && off == OFF_IEN)  ien  <= (ien  & ~wmask) | wdata;
      istat <= (istat & ~clr) | rise;
      IRQ   <= |(istat & ien);
    end
  end

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_DOUT:  rd_data[GPIO_WIDTH-1:0] = dout;
      OFF_DIR:   rd_data[GPIO_WIDTH-1:0] = dir;
      OFF_DIN:   rd_data[GPIO_WIDTH-1:0] = din;
      OFF_IEN:   rd_data[GPIO_WIDTH-1:0] = ien;
      OFF_ISTAT: rd_data[GPIO_WIDTH-1:0] = istat;
      default:   rd_data = '0;
    endcase
  end

  assign apb.PREADY  = access_done;
  assign apb.PSLVERR = complete && err;
  assign apb.PRDATA  = (complete && !apb.PWRITE && !err) ? rd_data : '0;

  assign GPIO_OUT     = dout;
  assign GPIO_OE      = dir;
  assign dbg.state    = state;
  assign dbg.wait_cnt = wait_cnt;

  logic unused_ok;
  assign unused_ok = ^{apb.PADDR, apb.PPROT, apb.PWDATA, bmask};
endmodule

// File: tb/tb_apb_gpio_slave.sv
// Randomized and directed bench for apb_gpio_slave with a register-level
// reference model and a response scoreboard fed by the driver.
module tb_apb_gpio_slave;
  import apb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int GW = 32;
  localparam int WS = 1;

  // ---------------- clock / reset ----------------
  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  apb_gpio_slave_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  logic [GW-1:0] GPIO_IN, GPIO_OUT, GPIO_OE;
  logic          IRQ;
  fsm_dbg_t      dbg;

  apb_gpio_slave #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STRB_WIDTH(SW),
    .GPIO_WIDTH(GW), .WAIT_STATES(WS)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (bus),
    .GPIO_IN (GPIO_IN),
    .GPIO_OUT(GPIO_OUT),
    .GPIO_OE (GPIO_OE),
    .IRQ     (IRQ),
    .dbg     (dbg)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [DW:0] exp_q[$];   // {pslverr, prdata}

  logic [GW-1:0] m_dout, m_dir, m_ien, m_istat, m_din;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_dout = '0; m_dir = '0; m_ien = '0; m_istat = '0; m_din = '0;
  endfunction

  function automatic logic [DW:0] model_access(input logic wr, input logic [AW-1:0] addr,
                                               input logic [DW-1:0] data, input logic [SW-1:0] strb,
                                               input logic [2:0] prot);
    int            off;
    logic          err;
    logic [GW-1:0] m, rd;
    off = int'(addr[4:2]);
    err = (addr[1:0] != 2'b00) || (off > 4) || (wr && off == 2) || (wr && off == 1 && !prot[0]);
    rd  = '0;
    m   = '0;
    for (int i = 0; i < GW; i++) m[i] = strb[i/8];
    if (!wr && !err) begin
      case (off)
        0: rd = m_dout;
        1: rd = m_dir;
        2: rd = m_din;
        3: rd = m_ien;
        default: rd = m_istat;
      endcase
    end
    if (wr && !err) begin
      case (off)
        0: m_dout = (m_dout & ~m) | (data[GW-1:0] & m);
        1: m_dir  = (m_dir  & ~m) | (data[GW-1:0] & m);
        3: m_ien  = (m_ien  & ~m) | (data[GW-1:0] & m);
        default: m_istat = m_istat & ~(data[GW-1:0] & m);
      endcase
    end
    return {err, DW'(rd)};
  endfunction

  // Monitor: pops one expected response per completed transfer
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge PCLK);
      if (PRESETn === 1'b1 && bus.PSEL === 1'b1) begin
        if (bus.PREADY === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp: got err=%b data=%h with nothing pending", bus.PSLVERR, bus.PRDATA);
          end else begin
            e = exp_q.pop_front();
            check("resp_err", DW'(bus.PSLVERR), DW'(e[DW]));
            check("resp_data", bus.PRDATA, e[DW-1:0]);
          end
        end else begin
          check("wait_resp_zero", {bus.PSLVERR, bus.PRDATA[DW-2:0]} | {31'b0, |bus.PRDATA}, '0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic xfer(input bit sync, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [SW-1:0] strb, input logic [2:0] prot);
    int n;
    if (sync) begin @(posedge PCLK); #1; end
    exp_q.push_back(model_access(wr, addr, data, strb, prot));
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = data; bus.PSTRB = strb; bus.PPROT = prot;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    n = 0;
    while (bus.PREADY !== 1'b1 && n < 40) begin
      @(posedge PCLK); #1;
      n++;
    end
    check("latency", DW'(n), DW'(WS));
  endtask

  task automatic idle();
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic check_outputs();
    @(posedge PCLK); #1;
    check("gpio_out", GPIO_OUT, m_dout);
    check("gpio_oe", GPIO_OE, m_dir);
    check("irq", DW'(IRQ), DW'(|(m_istat & m_ien)));
  endtask

  task automatic set_gpio_in(input logic [GW-1:0] v);
    @(posedge PCLK); #1;
    GPIO_IN = v;
    m_istat = m_istat | (v & ~m_din);
    m_din   = v;
    repeat (5) @(posedge PCLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pready"}, DW'(bus.PREADY), '0);
    check({tag, "_prdata"}, bus.PRDATA, '0);
    check({tag, "_pslverr"}, DW'(bus.PSLVERR), '0);
    check({tag, "_gpio_out"}, GPIO_OUT, '0);
    check({tag, "_gpio_oe"}, GPIO_OE, '0);
    check({tag, "_irq"}, DW'(IRQ), '0);
    check({tag, "_state"}, DW'(dbg.state), DW'(ST_IDLE));
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] a;
    PRESETn = 1'b0;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0; bus.PPROT = '0;
    GPIO_IN = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    check_reset_outputs("reset");
    PRESETn = 1'b1;

    // strobed DOUT write, unprivileged
    xfer(1, 1, 32'h0, 32'hA5A5_00FF, 4'b0011, 3'b000);
    idle(); check_outputs();
    check("dout_strobed", GPIO_OUT, 32'h0000_00FF);

    // DIR needs PPROT[0]
    xfer(1, 1, 32'h4, 32'hFFFF_0000, 4'hF, 3'b000);
    idle(); check_outputs();
    check("dir_prot_block", GPIO_OE, 32'h0);
    xfer(1, 1, 32'h4, 32'hFFFF_0000, 4'hF, 3'b001);
    idle(); check_outputs();
    check("dir_prot_ok", GPIO_OE, 32'hFFFF_0000);

    // input sync, sticky status, interrupt, W1C
    set_gpio_in(32'h10);
    xfer(1, 0, 32'h8, 32'h0, 4'h0, 3'b000);
    xfer(1, 0, 32'h10, 32'h0, 4'h0, 3'b000);
    idle();
    xfer(1, 1, 32'hC, 32'h10, 4'hF, 3'b000);
    idle(); check_outputs();
    check("irq_on", DW'(IRQ), 32'h1);
    xfer(1, 1, 32'h10, 32'h10, 4'hF, 3'b000);
    idle(); check_outputs();
    check("irq_off", DW'(IRQ), 32'h0);
    xfer(1, 0, 32'h10, 32'h0, 4'h0, 3'b000);
    idle();

    // rising edge lands on the same edge as a W1C of that bit
    set_gpio_in(32'h0);
    set_gpio_in(32'h10);
    set_gpio_in(32'h0);
    @(posedge PCLK); #1;
    GPIO_IN = 32'h10;
    xfer(0, 1, 32'h10, 32'h10, 4'hF, 3'b000);
    m_istat = m_istat | (32'h10 & ~m_din);
    m_din   = 32'h10;
    idle(); check_outputs();
    xfer(1, 0, 32'h10, 32'h0, 4'h0, 3'b000);
    idle();
    check("set_wins_model", m_istat & 32'h10, 32'h10);

    // error responses leave state untouched
    xfer(1, 0, 32'h18, 32'h0, 4'hF, 3'b000);
    xfer(1, 0, 32'h02, 32'h0, 4'hF, 3'b000);
    xfer(1, 1, 32'h08, 32'hFFFF_FFFF, 4'hF, 3'b001);
    xfer(1, 1, 32'h01, 32'hFFFF_FFFF, 4'hF, 3'b001);
    xfer(1, 1, 32'h1C, 32'hFFFF_FFFF, 4'hF, 3'b001);
    idle(); check_outputs();
    xfer(1, 0, 32'h0, 32'h0, 4'h0, 3'b000);
    xfer(1, 0, 32'h4, 32'h0, 4'h0, 3'b000);
    xfer(1, 0, 32'hC, 32'h0, 4'h0, 3'b000);
    idle();

    // randomized traffic, mixing back-to-back and idle gaps
    for (int i = 0; i < 80; i++) begin
      a = $urandom();
      a[4:2] = 3'($urandom_range(0, 7));
      a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      xfer(1, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) != 0) begin
        idle(); check_outputs();
        if (i % 6 == 0) set_gpio_in($urandom());
      end
    end
    idle();
    for (int r = 0; r < 5; r++) xfer(1, 0, 32'(r * 4), 32'h0, 4'h0, 3'b000);
    idle();

    // PSEL dropped during the wait state: aborted, no write
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 32'h0;
    bus.PWDATA = ~m_dout; bus.PSTRB = 4'hF; bus.PPROT = 3'b001;
    @(posedge PCLK); #1;
    bus.PENABLE = 1;
    check("abort_wait_ready", DW'(bus.PREADY), '0);
    bus.PSEL = 0; bus.PENABLE = 0;
    @(posedge PCLK); #1;
    check("abort_state", DW'(dbg.state), DW'(ST_IDLE));
    check("abort_pready", DW'(bus.PREADY), '0);
    check_outputs();
    xfer(1, 0, 32'h0, 32'h0, 4'h0, 3'b000);
    idle();

    // reset asserted mid-access
    set_gpio_in(32'h0);
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 32'h0;
    bus.PWDATA = 32'h1234_5678; bus.PSTRB = 4'hF; bus.PPROT = 3'b001;
    @(posedge PCLK); #1;
    bus.PENABLE = 1;
    PRESETn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    bus.PSEL = 0; bus.PENABLE = 0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    repeat (2) @(posedge PCLK);
    xfer(1, 0, 32'h0, 32'h0, 4'h0, 3'b000);
    xfer(1, 0, 32'h10, 32'h0, 4'h0, 3'b000);
    idle(); check_outputs();

    repeat (3) @(posedge PCLK);
    check("queue_empty", DW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
